// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU opcodes and forwarding-select codes
// used by the forwarding unit and the EX stage.
package mips_pkg;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_SLT  = 4'h6;
   localparam logic [3:0] ALU_SLTU = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;
   localparam logic [3:0] ALU_SLLV = 4'hB;
   localparam logic [3:0] ALU_LUI  = 4'hC;
   localparam logic [3:0] ALU_MULT = 4'hD;
   localparam logic [3:0] ALU_MFHI = 4'hE;
   localparam logic [3:0] ALU_MFLO = 4'hF;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EX_MEM  = 2'b01;
   localparam logic [1:0] FWD_MEM_WB  = 2'b10;

endpackage

// File: rtl/execute_alu.sv
// Combinational EX-stage ALU; also produces the 64-bit signed product that
// the stage commits to HI/LO when a MULT is accepted.
module execute_alu
   import mips_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_ALU_CTRL = 4
) (
   input  logic [NB_DATA-1:0]     a_i,
   input  logic [NB_DATA-1:0]     b_i,
   input  logic [4:0]             shamt_i,
   input  logic [NB_ALU_CTRL-1:0] op_i,
   input  logic [NB_DATA-1:0]     hi_i,
   input  logic [NB_DATA-1:0]     lo_i,
   output logic [NB_DATA-1:0]     result_o,
   output logic [2*NB_DATA-1:0]   product_o
);

   logic [2*NB_DATA-1:0] a_ext;
   logic [2*NB_DATA-1:0] b_ext;
   logic                 slt;
   logic                 sltu;

   // Low half of the product of sign-extended operands equals the signed product.
   assign a_ext     = {{NB_DATA{a_i[NB_DATA-1]}}, a_i};
   assign b_ext     = {{NB_DATA{b_i[NB_DATA-1]}}, b_i};
   assign product_o = a_ext * b_ext;

   assign slt  = $signed(a_i) < $signed(b_i);
   assign sltu = a_i < b_i;

   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_NOR:  result_o = ~(a_i | b_i);
         ALU_SLT:  result_o = {{(NB_DATA-1){1'b0}}, slt};
         ALU_SLTU: result_o = {{(NB_DATA-1){1'b0}}, sltu};
         ALU_SLL:  result_o = b_i << shamt_i;
         ALU_SRL:  result_o = b_i >> shamt_i;
         ALU_SRA:  result_o = $signed(b_i) >>> shamt_i;
         ALU_SLLV: result_o = b_i << a_i[4:0];
         ALU_LUI:  result_o = b_i << 16;
         ALU_MULT: result_o = '0;
         ALU_MFHI: result_o = hi_i;
         ALU_MFLO: result_o = lo_i;
         default:  result_o = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: forwarding muxes, ALU, HI/LO and the EX/MEM pipeline
// register with flush (bubble) taking priority over stall.
module execute_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_REG      = 5,
   parameter int NB_ALU_CTRL = 4
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   flush_i,
   input  logic [NB_DATA-1:0]     rs_data_i,
   input  logic [NB_DATA-1:0]     rt_data_i,
   input  logic [NB_DATA-1:0]     imm_ext_i,
   input  logic [4:0]             shamt_i,
   input  logic [NB_ALU_CTRL-1:0] alu_ctrl_i,
   input  logic                   alu_src_i,
   input  logic [1:0]             forward_signal_regA_i,
   input  logic [1:0]             forward_signal_regB_i,
   input  logic [NB_DATA-1:0]     ex_mem_fwd_data_i,
   input  logic [NB_DATA-1:0]     mem_wb_fwd_data_i,
   input  logic [NB_REG-1:0]      write_reg_i,
   input  logic                   reg_write_i,
   input  logic                   mem_read_i,
   input  logic                   mem_write_i,
   input  logic                   mem_to_reg_i,
   output logic [NB_DATA-1:0]     ex_mem_result_o,
   output logic [NB_DATA-1:0]     ex_mem_store_data_o,
   output logic [NB_REG-1:0]      ex_mem_writeReg_o,
   output logic                   ex_mem_reg_write_o,
   output logic                   ex_mem_mem_read_o,
   output logic                   ex_mem_mem_write_o,
   output logic                   ex_mem_mem_to_reg_o
);

   logic [NB_DATA-1:0]   fwd_a;
   logic [NB_DATA-1:0]   fwd_b;
   logic [NB_DATA-1:0]   op_b;
   logic [NB_DATA-1:0]   alu_result;
   logic [2*NB_DATA-1:0] product;

   logic [NB_DATA-1:0] result_d, result_q;
   logic [NB_DATA-1:0] store_d, store_q;
   logic [NB_REG-1:0]  write_reg_d, write_reg_q;
   logic               reg_write_d, reg_write_q;
   logic               mem_read_d, mem_read_q;
   logic               mem_write_d, mem_write_q;
   logic               mem_to_reg_d, mem_to_reg_q;
   logic [NB_DATA-1:0] hi_d, hi_q;
   logic [NB_DATA-1:0] lo_d, lo_q;

   // Select code 2'b11 is unused by the forwarding unit and falls back to the regfile.
   always_comb begin
      fwd_a = rs_data_i;
      case (forward_signal_regA_i)
         FWD_EX_MEM: fwd_a = ex_mem_fwd_data_i;
         FWD_MEM_WB: fwd_a = mem_wb_fwd_data_i;
         default:    fwd_a = rs_data_i;
      endcase
      fwd_b = rt_data_i;
      case (forward_signal_regB_i)
         FWD_EX_MEM: fwd_b = ex_mem_fwd_data_i;
         FWD_MEM_WB: fwd_b = mem_wb_fwd_data_i;
         default:    fwd_b = rt_data_i;
      endcase
   end

   assign op_b = alu_src_i ? imm_ext_i : fwd_b;

   execute_alu #(
      .NB_DATA     (NB_DATA),
      .NB_ALU_CTRL (NB_ALU_CTRL)
   ) u_alu (
      .a_i       (fwd_a),
      .b_i       (op_b),
      .shamt_i   (shamt_i),
      .op_i      (alu_ctrl_i),
      .hi_i      (hi_q),
      .lo_i      (lo_q),
      .result_o  (alu_result),
      .product_o (product)
   );

   always_comb begin
      result_d     = result_q;
      store_d      = store_q;
      write_reg_d  = write_reg_q;
      reg_write_d  = reg_write_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      if (flush_i) begin
         result_d     = '0;
         store_d      = '0;
         write_reg_d  = '0;
         reg_write_d  = 1'b0;
         mem_read_d   = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end else if (enable_i) begin
         result_d     = alu_result;
         store_d      = fwd_b;
         write_reg_d  = write_reg_i;
         reg_write_d  = reg_write_i;
         mem_read_d   = mem_read_i;
         mem_write_d  = mem_write_i;
         mem_to_reg_d = mem_to_reg_i;
         if (alu_ctrl_i == ALU_MULT) begin
            hi_d = product[2*NB_DATA-1:NB_DATA];
            lo_d = product[NB_DATA-1:0];
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         result_q     <= '0;
         store_q      <= '0;
         write_reg_q  <= '0;
         reg_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
      end else begin
         result_q     <= result_d;
         store_q      <= store_d;
         write_reg_q  <= write_reg_d;
         reg_write_q  <= reg_write_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
      end
   end

   assign ex_mem_result_o     = result_q;
   assign ex_mem_store_data_o = store_q;
   assign ex_mem_writeReg_o   = write_reg_q;
   assign ex_mem_reg_write_o  = reg_write_q;
   assign ex_mem_mem_read_o   = mem_read_q;
   assign ex_mem_mem_write_o  = mem_write_q;
   assign ex_mem_mem_to_reg_o = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: forwarding, ALU corners, HI/LO,
// stall, flush and asynchronous reset, with hand-computed expectations.
module tb_execute_stage;
   import mips_pkg::*;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic        flush_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic [31:0] imm_ext_i;
   logic [4:0]  shamt_i;
   logic [3:0]  alu_ctrl_i;
   logic        alu_src_i;
   logic [1:0]  forward_signal_regA_i;
   logic [1:0]  forward_signal_regB_i;
   logic [31:0] ex_mem_fwd_data_i;
   logic [31:0] mem_wb_fwd_data_i;
   logic [4:0]  write_reg_i;
   logic        reg_write_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic        mem_to_reg_i;
   logic [31:0] ex_mem_result_o;
   logic [31:0] ex_mem_store_data_o;
   logic [4:0]  ex_mem_writeReg_o;
   logic        ex_mem_reg_write_o;
   logic        ex_mem_mem_read_o;
   logic        ex_mem_mem_write_o;
   logic        ex_mem_mem_to_reg_o;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock_i = ~clock_i;

   execute_stage dut (
      .clock_i               (clock_i),
      .reset_i               (reset_i),
      .enable_i              (enable_i),
      .flush_i               (flush_i),
      .rs_data_i             (rs_data_i),
      .rt_data_i             (rt_data_i),
      .imm_ext_i             (imm_ext_i),
      .shamt_i               (shamt_i),
      .alu_ctrl_i            (alu_ctrl_i),
      .alu_src_i             (alu_src_i),
      .forward_signal_regA_i (forward_signal_regA_i),
      .forward_signal_regB_i (forward_signal_regB_i),
      .ex_mem_fwd_data_i     (ex_mem_fwd_data_i),
      .mem_wb_fwd_data_i     (mem_wb_fwd_data_i),
      .write_reg_i           (write_reg_i),
      .reg_write_i           (reg_write_i),
      .mem_read_i            (mem_read_i),
      .mem_write_i           (mem_write_i),
      .mem_to_reg_i          (mem_to_reg_i),
      .ex_mem_result_o       (ex_mem_result_o),
      .ex_mem_store_data_o   (ex_mem_store_data_o),
      .ex_mem_writeReg_o     (ex_mem_writeReg_o),
      .ex_mem_reg_write_o    (ex_mem_reg_write_o),
      .ex_mem_mem_read_o     (ex_mem_mem_read_o),
      .ex_mem_mem_write_o    (ex_mem_mem_write_o),
      .ex_mem_mem_to_reg_o   (ex_mem_mem_to_reg_o)
   );

   // Advance one edge and land 1 time unit after it, away from the edge.
   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic set_idle();
      enable_i = 1'b1; flush_i = 1'b0;
      rs_data_i = '0; rt_data_i = '0; imm_ext_i = '0; shamt_i = '0;
      alu_ctrl_i = ALU_ADD; alu_src_i = 1'b0;
      forward_signal_regA_i = FWD_REGFILE; forward_signal_regB_i = FWD_REGFILE;
      ex_mem_fwd_data_i = '0; mem_wb_fwd_data_i = '0;
      write_reg_i = '0; reg_write_i = 1'b0; mem_read_i = 1'b0;
      mem_write_i = 1'b0; mem_to_reg_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      set_idle();
      rs_data_i = 32'h11; rt_data_i = 32'h22; reg_write_i = 1'b1; write_reg_i = 5'd7;
      step();
      step();
      n_cmp++;
      if ({ex_mem_result_o, ex_mem_store_data_o} !== 64'h0) begin
         n_err++; $display("FAIL reset_data got=%h/%h exp=0/0", ex_mem_result_o, ex_mem_store_data_o);
      end
      n_cmp++;
      if ({ex_mem_writeReg_o, ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_write_o, ex_mem_mem_to_reg_o} !== 9'h0) begin
         n_err++; $display("FAIL reset_ctrl got wr=%h ctrl=%b%b%b%b exp=0", ex_mem_writeReg_o,
                           ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_write_o, ex_mem_mem_to_reg_o);
      end
      reset_i = 1'b0;
      set_idle();
   endtask

   task automatic test_forwarding();
      logic [1:0]  sel_a [4];
      logic [31:0] exp_a [4];
      sel_a = '{2'b00, 2'b01, 2'b10, 2'b11};
      exp_a = '{32'd8, 32'd10, 32'd12, 32'd8};
      set_idle();
      rs_data_i = 32'd5; rt_data_i = 32'd3; ex_mem_fwd_data_i = 32'd7; mem_wb_fwd_data_i = 32'd9;
      reg_write_i = 1'b1; write_reg_i = 5'd12;
      for (int i = 0; i < 4; i++) begin
         forward_signal_regA_i = sel_a[i];
         step();
         n_cmp++;
         if (ex_mem_result_o !== exp_a[i]) begin
            n_err++; $display("FAIL fwd_a sel=%b result got=%h exp=%h", sel_a[i], ex_mem_result_o, exp_a[i]);
         end
      end
      n_cmp++;
      if (ex_mem_writeReg_o !== 5'd12 || ex_mem_reg_write_o !== 1'b1) begin
         n_err++; $display("FAIL fwd_ctrl got wr=%0d rw=%b exp=12/1", ex_mem_writeReg_o, ex_mem_reg_write_o);
      end
      forward_signal_regA_i = FWD_REGFILE; forward_signal_regB_i = FWD_EX_MEM;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'd12 || ex_mem_store_data_o !== 32'd7) begin
         n_err++; $display("FAIL fwd_b01 got res=%h st=%h exp=c/7", ex_mem_result_o, ex_mem_store_data_o);
      end
      // SW: address = rs + imm, store data comes from the forwarded rt, not the immediate.
      forward_signal_regB_i = FWD_MEM_WB; alu_src_i = 1'b1; imm_ext_i = 32'd4;
      reg_write_i = 1'b0; mem_write_i = 1'b1;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'd9 || ex_mem_store_data_o !== 32'd9) begin
         n_err++; $display("FAIL fwd_sw got res=%h st=%h exp=9/9", ex_mem_result_o, ex_mem_store_data_o);
      end
      n_cmp++;
      if (ex_mem_mem_write_o !== 1'b1 || ex_mem_reg_write_o !== 1'b0) begin
         n_err++; $display("FAIL fwd_sw_ctrl got mw=%b rw=%b exp=1/0", ex_mem_mem_write_o, ex_mem_reg_write_o);
      end
      set_idle();
   endtask

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic        src;
      logic [4:0]  sh;
      logic [31:0] exp;
   } vec_t;

   task automatic test_alu_corners();
      vec_t v [14];
      v[0]  = '{ALU_SUB,  32'h0,        32'h1,        32'h0,    1'b0, 5'd0,  32'hFFFFFFFF};
      v[1]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 5'd0,  32'h1};
      v[2]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,    1'b0, 5'd0,  32'h0};
      v[3]  = '{ALU_SRA,  32'h0,        32'h80000000, 32'h0,    1'b0, 5'd4,  32'hF8000000};
      v[4]  = '{ALU_LUI,  32'h0,        32'h0,        32'h1234, 1'b1, 5'd0,  32'h12340000};
      v[5]  = '{ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    1'b0, 5'd0,  32'h00F000F0};
      v[6]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    1'b0, 5'd0,  32'hFFF0FFF0};
      v[7]  = '{ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    1'b0, 5'd0,  32'hFF00FF00};
      v[8]  = '{ALU_NOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    1'b0, 5'd0,  32'h000F000F};
      v[9]  = '{ALU_SLL,  32'h0,        32'h1,        32'h0,    1'b0, 5'd31, 32'h80000000};
      v[10] = '{ALU_SRL,  32'h0,        32'h80000000, 32'h0,    1'b0, 5'd4,  32'h08000000};
      v[11] = '{ALU_SLLV, 32'h24,       32'h3,        32'h0,    1'b0, 5'd0,  32'h30};
      v[12] = '{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h0,    1'b0, 5'd0,  32'h80000000};
      v[13] = '{ALU_SLT,  32'h1,        32'hFFFFFFFF, 32'h0,    1'b0, 5'd0,  32'h0};
      set_idle();
      for (int i = 0; i < 14; i++) begin
         alu_ctrl_i = v[i].op; rs_data_i = v[i].a; rt_data_i = v[i].b;
         imm_ext_i = v[i].imm; alu_src_i = v[i].src; shamt_i = v[i].sh;
         step();
         n_cmp++;
         if (ex_mem_result_o !== v[i].exp) begin
            n_err++; $display("FAIL alu[%0d] op=%h result got=%h exp=%h", i, v[i].op, ex_mem_result_o, v[i].exp);
         end
      end
      set_idle();
   endtask

   task automatic test_mult_back_to_back();
      set_idle();
      alu_ctrl_i = ALU_MULT; rs_data_i = 32'hFFFFFFFE; rt_data_i = 32'd3;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h0) begin
         n_err++; $display("FAIL mult_result got=%h exp=0", ex_mem_result_o);
      end
      alu_ctrl_i = ALU_MFHI; rs_data_i = 32'h0; rt_data_i = 32'h0;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'hFFFFFFFF) begin
         n_err++; $display("FAIL mfhi got=%h exp=ffffffff", ex_mem_result_o);
      end
      alu_ctrl_i = ALU_MFLO;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'hFFFFFFFA) begin
         n_err++; $display("FAIL mflo got=%h exp=fffffffa", ex_mem_result_o);
      end
      set_idle();
   endtask

   task automatic test_stall();
      set_idle();
      rs_data_i = 32'd5; rt_data_i = 32'd3; write_reg_i = 5'd9; reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
      step();
      enable_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alu_ctrl_i = ALU_MULT; rs_data_i = 32'd2 + i; rt_data_i = 32'd3 + i;
         write_reg_i = 5'd20 + 5'(i); reg_write_i = 1'b0; mem_to_reg_i = 1'b0; mem_read_i = 1'b1;
         step();
         n_cmp++;
         if (ex_mem_result_o !== 32'd8 || ex_mem_store_data_o !== 32'd3) begin
            n_err++; $display("FAIL stall_data cyc=%0d got=%h/%h exp=8/3", i, ex_mem_result_o, ex_mem_store_data_o);
         end
         n_cmp++;
         if (ex_mem_writeReg_o !== 5'd9 || {ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_to_reg_o} !== 3'b101) begin
            n_err++; $display("FAIL stall_ctrl cyc=%0d got wr=%0d ctrl=%b%b%b exp=9/101", i, ex_mem_writeReg_o,
                              ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_to_reg_o);
         end
      end
      set_idle();
      alu_ctrl_i = ALU_MFLO;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'hFFFFFFFA) begin
         n_err++; $display("FAIL stall_mult_lo got=%h exp=fffffffa", ex_mem_result_o);
      end
      set_idle();
   endtask

   task automatic test_flush();
      set_idle();
      alu_ctrl_i = ALU_MULT; rs_data_i = 32'd7; rt_data_i = 32'd5;
      write_reg_i = 5'd3; reg_write_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b1; mem_to_reg_i = 1'b1;
      enable_i = 1'b0; flush_i = 1'b1;
      step();
      n_cmp++;
      if ({ex_mem_result_o, ex_mem_store_data_o} !== 64'h0) begin
         n_err++; $display("FAIL flush_stall_data got=%h/%h exp=0/0", ex_mem_result_o, ex_mem_store_data_o);
      end
      n_cmp++;
      if ({ex_mem_writeReg_o, ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_write_o, ex_mem_mem_to_reg_o} !== 9'h0) begin
         n_err++; $display("FAIL flush_stall_ctrl got wr=%h ctrl=%b%b%b%b exp=0", ex_mem_writeReg_o,
                           ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_write_o, ex_mem_mem_to_reg_o);
      end
      enable_i = 1'b1;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h0 || ex_mem_reg_write_o !== 1'b0) begin
         n_err++; $display("FAIL flush_en got res=%h rw=%b exp=0/0", ex_mem_result_o, ex_mem_reg_write_o);
      end
      set_idle();
      alu_ctrl_i = ALU_MFLO;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'hFFFFFFFA) begin
         n_err++; $display("FAIL flush_lo got=%h exp=fffffffa", ex_mem_result_o);
      end
      alu_ctrl_i = ALU_MFHI;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'hFFFFFFFF) begin
         n_err++; $display("FAIL flush_hi got=%h exp=ffffffff", ex_mem_result_o);
      end
      set_idle();
   endtask

   task automatic test_reset_midstream();
      set_idle();
      alu_ctrl_i = ALU_ADD; rs_data_i = 32'h100; rt_data_i = 32'h23;
      write_reg_i = 5'd17; reg_write_i = 1'b1; mem_to_reg_i = 1'b1;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h123) begin
         n_err++; $display("FAIL pre_reset got=%h exp=123", ex_mem_result_o);
      end
      #2 reset_i = 1'b1;
      #1;
      n_cmp++;
      if ({ex_mem_result_o, ex_mem_store_data_o} !== 64'h0) begin
         n_err++; $display("FAIL async_reset_data got=%h/%h exp=0/0", ex_mem_result_o, ex_mem_store_data_o);
      end
      n_cmp++;
      if ({ex_mem_writeReg_o, ex_mem_reg_write_o, ex_mem_mem_to_reg_o} !== 7'h0) begin
         n_err++; $display("FAIL async_reset_ctrl got wr=%h rw=%b m2r=%b exp=0", ex_mem_writeReg_o,
                           ex_mem_reg_write_o, ex_mem_mem_to_reg_o);
      end
      alu_ctrl_i = ALU_MULT; rs_data_i = 32'd4; rt_data_i = 32'd4;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h0 || ex_mem_reg_write_o !== 1'b0) begin
         n_err++; $display("FAIL held_reset got res=%h rw=%b exp=0/0", ex_mem_result_o, ex_mem_reg_write_o);
      end
      reset_i = 1'b0;
      alu_ctrl_i = ALU_MFHI; rs_data_i = 32'h0; rt_data_i = 32'h0;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h0) begin
         n_err++; $display("FAIL post_reset_mfhi got=%h exp=0", ex_mem_result_o);
      end
      alu_ctrl_i = ALU_MFLO;
      step();
      n_cmp++;
      if (ex_mem_result_o !== 32'h0) begin
         n_err++; $display("FAIL post_reset_mflo got=%h exp=0", ex_mem_result_o);
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_alu_corners();
      test_mult_back_to_back();
      test_stall();
      test_flush();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline, directly downstream of the forwarding unit.
- Consumes the two 2-bit forward selects, picks operand A/B from the register file, EX/MEM or MEM/WB, and executes the ALU op.
- Holds HI/LO for MULT/MFHI/MFLO and registers all results and control into the EX/MEM pipeline register with stall and flush.

Parameters:
- NB_DATA, 32, datapath width
- NB_REG, 5, register-index width
- NB_ALU_CTRL, 4, ALU opcode width

Ports:
- clock_i  in  1  pipeline clock
- reset_i  in  1  asynchronous reset, active-high
- enable_i  in  1  advance EX/MEM register (0 = stall, hold)
- flush_i  in  1  insert bubble into EX/MEM
- rs_data_i  in  NB_DATA  register-file rs value (ID/EX)
- rt_data_i  in  NB_DATA  register-file rt value (ID/EX)
- imm_ext_i  in  NB_DATA  sign/zero-extended immediate
- shamt_i  in  5  shift amount field
- alu_ctrl_i  in  NB_ALU_CTRL  operation select
- alu_src_i  in  1  1 = operand B is imm_ext_i
- forward_signal_regA_i  in  2  00 regfile, 01 EX/MEM, 10 MEM/WB, 11 = regfile
- forward_signal_regB_i  in  2  same encoding for rt
- ex_mem_fwd_data_i  in  NB_DATA  value forwarded from the EX/MEM stage
- mem_wb_fwd_data_i  in  NB_DATA  value forwarded from the MEM/WB stage
- write_reg_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  NB_REG/1/1/1/1  ID/EX destination and control
- ex_mem_result_o  out  NB_DATA  registered ALU result
- ex_mem_store_data_o  out  NB_DATA  registered forwarded rt (store data)
- ex_mem_writeReg_o  out  NB_REG  registered destination
- ex_mem_reg_write_o, ex_mem_mem_read_o, ex_mem_mem_write_o, ex_mem_mem_to_reg_o  out  1 each  registered control

Behaviour:
- Reset (async, high): all outputs 0; HI = LO = 0. Outputs stay 0 while reset_i is high, and reset overrides any operation in progress.
- Operand A is the forward-mux(rs) result.
- fwdB is the forward-mux(rt) result. Operand B is imm_ext_i if alu_src_i = 1, else fwdB.
- Select code 11 is treated as 00.
- Store data is always fwdB, never the immediate.
- ALU ops (all arithmetic mod 2^NB_DATA, no overflow trap):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT signed and 7 SLTU produce 1 or 0.
  - 8 SLL B by shamt, 9 SRL B by shamt, A SRA B by shamt.
  - B SLLV: B << A[4:0].
  - C LUI: B << 16.
  - D MULT: signed A*B, 64-bit product to {HI,LO}; result = 0.
  - E MFHI: result = HI. F MFLO: result = LO.
- Latency: 1 cycle. Inputs at edge N appear on the EX/MEM outputs after edge N.
- Priority at each edge: reset > flush_i > !enable_i > update.
- flush_i = 1 (regardless of enable_i): result, store data, writeReg and all control outputs load 0. HI/LO are not written.
- enable_i = 0 and flush_i = 0: all EX/MEM outputs and HI/LO hold.
- Update: EX/MEM outputs load the new values. HI/LO are written only when op = MULT.
- MFHI/MFLO immediately following a MULT read the new HI/LO (written at the prior edge).
- MULT stalled (enable_i = 0) does not write HI/LO until it is accepted.
- Forward-select inputs are purely combinational into the muxes; no registering of the selects.

Decomposition:
- Shared package mips_pkg holds:
  - ALU opcode localparams (ALU_ADD..ALU_MFLO)
  - forward-select codes (FWD_REGFILE = 2'b00, FWD_EX_MEM = 2'b01, FWD_MEM_WB = 2'b10), matching the forwarding unit
- Sub-module: execute_alu, purely combinational (A, B, shamt, op, HI, LO -> result, 64-bit product).
- Forward muxes, HI/LO and the EX/MEM register stay in execute_stage.

Test Plan:
- Reset mid-stream: assert reset_i asynchronously with valid data in flight -> all outputs 0 before the next edge; a following MFHI returns 0.
- Forwarding:
  - rs = 5, ex_mem_fwd = 7, mem_wb_fwd = 9, rt = 3, ADD.
  - selA = 01 -> result 10. selA = 10 -> result 12. selA = 11 -> result 8.
  - selB = 10, SW -> store data 9.
- ALU corners:
  - SUB 0 - 1 -> FFFFFFFF.
  - SLT FFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
  - SRA 80000000 by 4 -> F8000000.
  - LUI imm 1234 -> 12340000.
- MULT/MFHI back-to-back: MULT FFFFFFFE * 3 (i.e. -2*3) -> HI = FFFFFFFF, LO = FFFFFFFA; next-cycle MFHI -> FFFFFFFF; MFLO -> FFFFFFFA.
- Stall/flush:
  - enable_i = 0 for 3 cycles with changing inputs -> outputs frozen.
  - flush_i = 1 with enable_i = 0 and MULT present -> control/result 0, HI/LO unchanged.
